// File: rtl/gather_64_16_pkg.sv
// Shared widths, FSM encoding and lane-select helper for the 64->16 gather path.
package gather_64_16_pkg;

    localparam int unsigned LANE_W     = 16;
    localparam int unsigned LANES      = 4;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned IN_W       = LANE_W * LANES;
    localparam int unsigned LANE_IDX_W = $clog2(LANES);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [LANE_W-1:0] lane_sel(input logic [IN_W-1:0]       word,
                                                   input logic [LANE_IDX_W-1:0] idx);
        return word[int'(idx) * LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with head and next-to-head read ports so a consumer can chain words without a bubble.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic [WIDTH-1:0] second_c,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        rd_ptr_inc = rd_ptr + PTR_W'(1);
        count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage is not reset; entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign head_c   = mem[rd_ptr];
    assign second_c = mem[rd_ptr_inc];

endmodule

// File: rtl/gather_64_16.sv
// Serializes buffered 64-bit four-lane words into a 16-bit lane stream, lane 0 first.
module gather_64_16
    import gather_64_16_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_v,
    output logic                  in_rdy,
    input  logic [IN_W-1:0]       in_data,
    output logic                  out_v,
    input  logic                  out_rdy,
    output logic [LANE_W-1:0]     out_data,
    output logic [LANE_IDX_W-1:0] out_lane,
    output logic                  out_last
);

    state_t                  state_q;
    state_t                  state_nxt;
    logic                    push;
    logic                    pop;
    logic [IN_W-1:0]         fifo_head;
    logic [IN_W-1:0]         fifo_second;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        count_nxt;
    logic                    in_rdy_nxt;
    logic                    out_v_nxt;
    logic [LANE_W-1:0]       out_data_nxt;
    logic [LANE_IDX_W-1:0]   out_lane_nxt;
    logic                    out_last_nxt;
    logic [LANE_IDX_W-1:0]   lane_inc;

    assign push = in_v && in_rdy && !fifo_full;

    sync_fifo #(
        .WIDTH (IN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_data  (in_data),
        .pop      (pop),
        .head_c   (fifo_head),
        .second_c (fifo_second),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            in_rdy   <= 1'b0;
            out_v    <= 1'b0;
            out_data <= '0;
            out_lane <= '0;
            out_last <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            in_rdy   <= in_rdy_nxt;
            out_v    <= out_v_nxt;
            out_data <= out_data_nxt;
            out_lane <= out_lane_nxt;
            out_last <= out_last_nxt;
        end
    end

    // Next lane selection; after the last lane the next word comes from the FIFO or the same-cycle push.
    always_comb begin
        state_nxt    = state_q;
        pop          = 1'b0;
        out_v_nxt    = out_v;
        out_data_nxt = out_data;
        out_lane_nxt = out_lane;
        out_last_nxt = out_last;
        lane_inc     = out_lane + LANE_IDX_W'(1);

        unique case (state_q)
            IDLE: begin
                out_v_nxt    = 1'b0;
                out_last_nxt = 1'b0;
                if (!fifo_empty) begin
                    state_nxt    = SEND;
                    out_v_nxt    = 1'b1;
                    out_lane_nxt = '0;
                    out_data_nxt = lane_sel(fifo_head, '0);
                    out_last_nxt = (LAST_LANE == '0);
                end
            end
            SEND: begin
                if (out_v && out_rdy) begin
                    if (out_lane == LAST_LANE) begin
                        pop          = 1'b1;
                        out_lane_nxt = '0;
                        out_last_nxt = (LAST_LANE == '0);
                        if (fifo_count > CNT_W'(1)) begin
                            out_data_nxt = lane_sel(fifo_second, '0);
                        end else if (push) begin
                            out_data_nxt = lane_sel(in_data, '0);
                        end else begin
                            state_nxt    = IDLE;
                            out_v_nxt    = 1'b0;
                            out_last_nxt = 1'b0;
                        end
                    end else begin
                        out_lane_nxt = lane_inc;
                        out_data_nxt = lane_sel(fifo_head, lane_inc);
                        out_last_nxt = (lane_inc == LAST_LANE);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        count_nxt  = fifo_count + CNT_W'(push) - CNT_W'(pop);
        in_rdy_nxt = (count_nxt < CNT_W'(FIFO_DEPTH));
    end

endmodule

// File: tb/tb_gather_64_16.sv
// Scoreboard bench for gather_64_16: accepted words expand into expected lanes, a monitor checks emitted lanes.
module tb_gather_64_16;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  lane;
        logic        last;
    } lane_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_v;
    logic        in_rdy;
    logic [63:0] in_data;
    logic        out_v;
    logic        out_rdy;
    logic [15:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;

    lane_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    logic        stalled = 1'b0;
    logic [15:0] prev_d;
    logic [1:0]  prev_lane;
    logic        prev_last;

    gather_64_16 dut (
        .clk      (clk),
        .rst      (rst),
        .in_v     (in_v),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_v    (out_v),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_lane (out_lane),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected-lane generator: every accepted word yields four lanes, lane 0 = bits [15:0].
    always @(negedge clk) begin
        if (rst && in_v && in_rdy) begin
            for (int k = 0; k < 4; k++) begin
                lane_t e;
                e.d    = in_data[16*k +: 16];
                e.lane = 2'(k);
                e.last = (k == 3);
                exp_q.push_back(e);
            end
        end
    end

    // Output monitor: compare accepted lanes, check stall stability and idle out_last.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("hold", {out_v, out_data, out_lane, out_last},
                      {1'b1, prev_d, prev_lane, prev_last});
            if (!out_v)
                check("idle_last", 64'(out_last), 64'(0));
            if (out_v && out_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_lane: got data %0h lane %0d with nothing expected at %0t",
                             out_data, out_lane, $time);
                end else begin
                    lane_t e;
                    e = exp_q.pop_front();
                    check("lane", {out_data, out_lane, out_last}, {e.d, e.lane, e.last});
                end
            end
            stalled   = out_v && !out_rdy;
            prev_d    = out_data;
            prev_lane = out_lane;
            prev_last = out_last;
        end
    end

    task automatic drain();
        bit done = 0;
        in_v    = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            done = (exp_q.size() == 0) && !out_v;
        end
        check("drain", 64'(done), 64'(1));
    endtask

    initial begin
        logic [63:0] w;
        logic [63:0] words [3];
        logic [15:0] single_exp [4];
        int          pushed;
        int          run;
        bit          started;
        bit          ended;
        bit          saw_full;
        bit          acc;
        bit          found;
        int          vcount;

        rst     = 1'b0;
        in_v    = 1'b1;
        in_data = {$urandom, $urandom};
        out_rdy = 1'b1;

        // Reset hold with in_v asserted
        repeat (3) tick();
        check("rst_in_rdy", 64'(in_rdy), 64'(0));
        check("rst_out", {out_v, out_data, out_lane, out_last}, 64'(0));
        rst  = 1'b1;
        in_v = 1'b0;
        tick();
        check("rel_in_rdy", 64'(in_rdy), 64'(1));
        check("rel_out_v", 64'(out_v), 64'(0));

        // Single word
        single_exp[0] = 16'h1111;
        single_exp[1] = 16'h2222;
        single_exp[2] = 16'h3333;
        single_exp[3] = 16'h4444;
        in_v    = 1'b1;
        in_data = 64'h4444_3333_2222_1111;
        tick();
        in_v = 1'b0;
        check("latency_idle", 64'(out_v), 64'(0));
        tick();
        for (int k = 0; k < 4; k++) begin
            check("single", {out_v, out_data, out_lane, out_last},
                  {1'b1, single_exp[k], 2'(k), (k == 3)});
            tick();
        end
        check("single_end", 64'(out_v), 64'(0));

        // Back-to-back three words
        for (int i = 0; i < 3; i++) words[i] = {$urandom, $urandom};
        pushed = 0; run = 0; started = 0; ended = 0; saw_full = 0;
        for (int i = 0; i < 60 && !ended; i++) begin
            in_v    = (pushed < 3);
            in_data = words[pushed % 3];
            acc     = in_v && in_rdy;
            tick();
            if (acc) pushed++;
            if (!in_rdy) saw_full = 1;
            if (out_v) begin
                run++;
                started = 1;
            end else if (started) begin
                ended = 1;
            end
        end
        in_v = 1'b0;
        check("b2b_run", 64'(run), 64'(12));
        check("b2b_full", 64'(saw_full), 64'(1));
        drain();

        // Backpressure on lane 1
        w       = {$urandom, $urandom};
        in_v    = 1'b1;
        in_data = w;
        tick();
        in_v = 1'b0;
        tick();
        tick();
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold", {out_v, out_data, out_lane}, {1'b1, w[31:16], 2'd1});
            tick();
        end
        out_rdy = 1'b1;
        check("bp_hold", {out_v, out_data, out_lane}, {1'b1, w[31:16], 2'd1});
        tick();
        check("bp_resume", {out_v, out_data, out_lane}, {1'b1, w[47:32], 2'd2});
        drain();

        // Full FIFO with pop in the same cycle
        out_rdy = 1'b0;
        in_v    = 1'b1;
        in_data = {$urandom, $urandom};
        tick();
        in_data = {$urandom, $urandom};
        tick();
        in_data = {$urandom, $urandom};
        check("full_rdy", 64'(in_rdy), 64'(0));
        out_rdy = 1'b1;
        found   = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (out_v && out_lane == 2'd3) found = 1;
            else tick();
        end
        check("full_pop_found", 64'(found), 64'(1));
        check("full_pop_rdy", 64'(in_rdy), 64'(0));
        tick();
        check("full_pop_rise", 64'(in_rdy), 64'(1));
        tick();
        in_v = 1'b0;
        drain();

        // Reset mid-word with a second word buffered
        out_rdy = 1'b1;
        in_v    = 1'b1;
        in_data = {$urandom, $urandom};
        tick();
        in_data = {$urandom, $urandom};
        tick();
        in_v = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("mid_rst_out_v", 64'(out_v), 64'(0));
        rst    = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_v) vcount++;
        end
        check("mid_rst_no_lanes", 64'(vcount), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_v    = 1'($urandom_range(0, 1));
            in_data = {$urandom, $urandom};
            out_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
